// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// instruction classes, ALU operations, datapath select codes and trap causes.
// No logic here beyond the opcode-to-class lookup.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        CLS_NONE, CLS_R, CLS_IALU, CLS_LOAD, CLS_STORE,
        CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC
    } instr_class_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
    } alu_op_e;

    localparam logic [1:0] OPA_RS1 = 2'd0, OPA_PC = 2'd1, OPA_ZERO = 2'd2;
    localparam logic       OPB_RS2 = 1'b0, OPB_IMM = 1'b1;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
    localparam logic [1:0] NPC_PLUS4 = 2'd0, NPC_PC_IMM = 2'd1, NPC_ALU = 2'd2, NPC_TRAP = 2'd3;
    localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd0, CAUSE_FETCH_TO = 2'd1, CAUSE_DATA_TO = 2'd2;

    function automatic instr_class_e decode_class(input logic [6:0] opc);
        case (opc)
            OPC_R:      return CLS_R;
            OPC_IALU:   return CLS_IALU;
            OPC_LOAD:   return CLS_LOAD;
            OPC_STORE:  return CLS_STORE;
            OPC_BRANCH: return CLS_BRANCH;
            OPC_JAL:    return CLS_JAL;
            OPC_JALR:   return CLS_JALR;
            OPC_LUI:    return CLS_LUI;
            OPC_AUIPC:  return CLS_AUIPC;
            default:    return CLS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// ALU operation select from instruction class and funct fields.
// Latency: combinational, zero cycles.
// Backpressure: none; pure decode.
module alu_op_decoder
    import riscv_ctrl_pkg::*;
(
    input  instr_class_e instr_class,
    input  logic [2:0]   func_3,
    input  logic         func_7_bit_6,
    output alu_op_e      alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (instr_class)
            CLS_R, CLS_IALU: begin
                case (func_3)
                    // Immediate forms have no SUBI: bit 30 belongs to the immediate.
                    3'b000: alu_op = (instr_class == CLS_R && func_7_bit_6) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_op = ALU_SLL;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b101: alu_op = func_7_bit_6 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            CLS_BRANCH: alu_op = ALU_SUB;
            CLS_LUI:    alu_op = ALU_PASSB;
            default:    alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with traps.
// Latency: ALU/jump 4, branch 3, store 4, load 5 cycles at zero wait states.
// Backpressure: stalls on imem_ready/dmem_ready, traps after MEM_TIMEOUT waits.
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 15,
    parameter int ALU_OP_W     = 4,
    parameter int RETIRE_CNT_W = 32
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              opcode,
    input  logic [2:0]              func_3,
    input  logic                    func_7_bit_6,
    input  logic                    branch_taken,
    input  logic                    imem_ready,
    input  logic                    dmem_ready,
    output logic                    imem_req,
    output logic                    ir_write,
    output logic                    dmem_req,
    output logic                    load,
    output logic                    store,
    output logic                    write,
    output logic                    pc_write,
    output logic [1:0]              alu_operand_a_selector,
    output logic                    alu_operand_b_selector,
    output logic [2:0]              immediate_selector,
    output logic [1:0]              next_pc_selector,
    output logic [1:0]              wb_selector,
    output logic [ALU_OP_W-1:0]     alu_operations_selector,
    output logic                    trap,
    output logic [1:0]              trap_cause,
    output logic                    instr_retired,
    output logic [RETIRE_CNT_W-1:0] retired_count,
    output logic [2:0]              state
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e                  state_q, state_d;
    logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
    instr_class_e            instr_class_q, instr_class_d;
    logic [1:0]              cause_q, cause_d;
    logic [RETIRE_CNT_W-1:0] retired_count_q, retired_count_d;

    alu_op_e alu_op;
    logic    commit;
    logic    wait_expired;
    logic    exec_phase;

    alu_op_decoder u_alu_op_decoder (
        .instr_class  (instr_class_q),
        .func_3       (func_3),
        .func_7_bit_6 (func_7_bit_6),
        .alu_op       (alu_op)
    );

    // The cycle that would push the count to MEM_TIMEOUT is the last one allowed.
    assign wait_expired = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));
    assign exec_phase   = state_q inside {ST_EXECUTE, ST_MEMORY, ST_WRITEBACK};
    assign commit       = (state_q == ST_WRITEBACK)
                       || (state_q == ST_EXECUTE && instr_class_q == CLS_BRANCH)
                       || (state_q == ST_MEMORY && instr_class_q == CLS_STORE && dmem_ready);

    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = wait_cnt_q;
        instr_class_d   = instr_class_q;
        cause_d         = cause_q;
        retired_count_d = commit ? retired_count_q + RETIRE_CNT_W'(1) : retired_count_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_FETCH_TO;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_DECODE: begin
                instr_class_d = decode_class(opcode);
                if (instr_class_d == CLS_NONE) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                case (instr_class_q)
                    CLS_LOAD, CLS_STORE: state_d = ST_MEMORY;
                    CLS_BRANCH:          state_d = ST_FETCH;
                    default:             state_d = ST_WRITEBACK;
                endcase
            end
            ST_MEMORY: begin
                if (dmem_ready) begin
                    state_d = (instr_class_q == CLS_STORE) ? ST_FETCH : ST_WRITEBACK;
                end else if (wait_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_DATA_TO;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: state_d = ST_FETCH;
        endcase
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_FETCH;
            wait_cnt_q      <= '0;
            instr_class_q   <= CLS_NONE;
            cause_q         <= CAUSE_ILLEGAL;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            wait_cnt_q      <= wait_cnt_d;
            instr_class_q   <= instr_class_d;
            cause_q         <= cause_d;
            retired_count_q <= retired_count_d;
        end
    end

    always_comb begin
        imem_req                = 1'b0;
        ir_write                = 1'b0;
        dmem_req                = 1'b0;
        load                    = 1'b0;
        store                   = 1'b0;
        write                   = 1'b0;
        pc_write                = 1'b0;
        alu_operand_a_selector  = OPA_RS1;
        alu_operand_b_selector  = OPB_RS2;
        immediate_selector      = IMM_I;
        next_pc_selector        = NPC_PLUS4;
        wb_selector             = WB_ALU;
        alu_operations_selector = '0;
        trap                    = 1'b0;
        trap_cause              = CAUSE_ILLEGAL;
        // ALU selects stay stable from EXECUTE until the instruction leaves.
        if (exec_phase) begin
            alu_operations_selector = ALU_OP_W'(alu_op);
            alu_operand_b_selector  = (instr_class_q == CLS_R || instr_class_q == CLS_BRANCH) ? OPB_RS2 : OPB_IMM;
            case (instr_class_q)
                CLS_STORE:  immediate_selector = IMM_S;
                CLS_BRANCH: immediate_selector = IMM_B;
                CLS_JAL: begin
                    alu_operand_a_selector = OPA_PC;
                    immediate_selector     = IMM_J;
                end
                CLS_LUI: begin
                    alu_operand_a_selector = OPA_ZERO;
                    immediate_selector     = IMM_U;
                end
                CLS_AUIPC: begin
                    alu_operand_a_selector = OPA_PC;
                    immediate_selector     = IMM_U;
                end
                default: ;
            endcase
        end
        case (state_q)
            ST_FETCH: begin
                // FETCH is also the reset state; requests only leave once reset releases.
                imem_req = rst_n;
                ir_write = rst_n & imem_ready;
            end
            ST_EXECUTE: begin
                if (instr_class_q == CLS_BRANCH) begin
                    pc_write         = 1'b1;
                    next_pc_selector = branch_taken ? NPC_PC_IMM : NPC_PLUS4;
                end
            end
            ST_MEMORY: begin
                dmem_req = 1'b1;
                load     = (instr_class_q == CLS_LOAD);
                store    = (instr_class_q == CLS_STORE);
                pc_write = (instr_class_q == CLS_STORE) && dmem_ready;
            end
            ST_WRITEBACK: begin
                write    = 1'b1;
                pc_write = 1'b1;
                case (instr_class_q)
                    CLS_LOAD:          wb_selector = WB_MEM;
                    CLS_JAL, CLS_JALR: wb_selector = WB_PC4;
                    default:           wb_selector = WB_ALU;
                endcase
                case (instr_class_q)
                    CLS_JAL:  next_pc_selector = NPC_PC_IMM;
                    CLS_JALR: next_pc_selector = NPC_ALU;
                    default:  next_pc_selector = NPC_PLUS4;
                endcase
            end
            ST_TRAP: begin
                trap             = 1'b1;
                trap_cause       = cause_q;
                pc_write         = 1'b1;
                next_pc_selector = NPC_TRAP;
            end
            default: ;
        endcase
    end

    assign instr_retired = commit;
    assign retired_count = retired_count_q;
    assign state         = state_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multi-cycle successor to the single-cycle control decoder. An FSM sequences each RV32I instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. It uses ready-based handshakes to instruction and data memory, a wait-state timeout, illegal-opcode trapping and a retired-instruction counter. It sits between the IR/datapath and the memories and drives every datapath select and enable.

Parameters:
MEM_TIMEOUT, 15, max cycles a memory request may wait for ready before trapping (must be ≥1)
ALU_OP_W, 4, width of alu_operations_selector
RETIRE_CNT_W, 32, width of retired_count

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
opcode  in  7  IR[6:0], stable from cycle after ir_write
func_3  in  3  IR[14:12]
func_7_bit_6  in  1  IR[30]
branch_taken  in  1  comparator result, valid in EXECUTE
imem_ready  in  1  instruction memory ready
dmem_ready  in  1  data memory ready
imem_req  out  1  instruction fetch request
ir_write  out  1  IR load enable
dmem_req  out  1  data memory request
load  out  1  data read
store  out  1  data write
write  out  1  register-file write enable
pc_write  out  1  PC update enable
alu_operand_a_selector  out  2  0 rs1, 1 pc, 2 zero
alu_operand_b_selector  out  1  0 rs2, 1 imm
immediate_selector  out  3  0 I, 1 S, 2 B, 3 U, 4 J
next_pc_selector  out  2  0 pc+4, 1 pc+imm, 2 alu&~1, 3 trap vector
wb_selector  out  2  0 alu, 1 mem, 2 pc+4
alu_operations_selector  out  ALU_OP_W  ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10
trap  out  1  one-cycle trap pulse
trap_cause  out  2  0 illegal, 1 fetch timeout, 2 data timeout; valid with trap
instr_retired  out  1  one-cycle pulse per committed instruction
retired_count  out  RETIRE_CNT_W  committed-instruction count, wraps
state  out  3  current FSM state, for debug

Behaviour:
- Reset (async assert, sync release):
  - state=FETCH.
  - Wait counter, retired_count and decoded-class register cleared.
  - All outputs 0 except the combinational imem_req, which is 1 once rst_n releases.
- Unlisted outputs are 0 in every state. Selectors hold their EXECUTE values through MEMORY and WRITEBACK.
- FETCH:
  - imem_req=1.
  - imem_ready=1 → ir_write=1 in the same cycle, then go to DECODE.
  - Otherwise the wait counter increments. When it reaches MEM_TIMEOUT, go to TRAP with cause 1.
  - If imem_ready and the timeout occur in the same cycle, ready wins.
- DECODE (1 cycle):
  - Registers the instruction class from opcode: R 0110011, IALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Any other opcode → TRAP, cause 0.
- EXECUTE (1 cycle), drives the ALU selects:
  - R: rs1/rs2, op from func_3 and func_7_bit_6.
  - IALU: rs1/imm I. func_7_bit_6 is honoured only for func_3=101 (SRAI). func_3=000 is always ADD.
  - LOAD: rs1/imm I, ADD. STORE: rs1/imm S, ADD.
  - BRANCH: rs1/rs2, SUB. Commits here with pc_write=1 and next_pc_selector = branch_taken ? 1 : 0, then goes to FETCH.
  - JAL: pc/imm J, ADD. JALR: rs1/imm I, ADD. LUI: zero/imm U, PASSB. AUIPC: pc/imm U, ADD.
  - Next state: LOAD/STORE → MEMORY; others → WRITEBACK.
- MEMORY:
  - dmem_req=1, with load or store held.
  - dmem_ready with STORE → pc_write=1 (sel 0), commit, go to FETCH.
  - dmem_ready with LOAD → WRITEBACK.
  - Timeout (same rule as FETCH) → TRAP with cause 2. Ready wins ties.
- WRITEBACK (1 cycle):
  - write=1 and pc_write=1.
  - wb_selector: 1 for LOAD, 2 for JAL/JALR, else 0.
  - next_pc_selector: 1 for JAL, 2 for JALR, else 0.
  - Commits, then goes to FETCH.
- TRAP (1 cycle):
  - trap=1 with trap_cause, pc_write=1, next_pc_selector=3, then go to FETCH.
  - No write, no retire.
- Commit: instr_retired pulses and retired_count increments (modulo 2^RETIRE_CNT_W) in the commit cycle.
- Wait counter: cleared on every state entry; width $clog2(MEM_TIMEOUT+1).
- Zero-wait latency in cycles: ALU/LUI/AUIPC/JAL/JALR 4, branch 3, store 4, load 5.
- rst_n asserted mid-instruction: immediate return to the reset state; in-flight requests drop the same cycle.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - the state enum (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP);
  - the opcode constants;
  - the ALU-op enum;
  - the operand-A, immediate, next-PC and writeback selector encodings;
  - the trap-cause codes.
- Sub-module alu_op_decoder (combinational): class, func_3, func_7_bit_6 → ALU op.

Test Plan:
- ADD (opcode 0110011, func_3 000, f7b6 0), both ready held 1 → imem_req@0, ir_write@0, alu op 0@2, write+pc_write@3, instr_retired@3, retired_count=1.
- SUB then SRAI (0010011, func_3 101, f7b6 1) → alu op 1 then 7. ADDI with f7b6 1 → op 0.
- LW with dmem_ready delayed 3 cycles → MEMORY lasts 4 cycles with load=1. WRITEBACK has wb_selector=1 and write=1. Total latency 8.
- BEQ with branch_taken 1, then 0 → commit in EXECUTE with next_pc_selector 1, then 0. write never asserted.
- imem_ready held 0, MEM_TIMEOUT=15 → TRAP after 15 FETCH cycles: trap=1, cause 1, pc_write=1, next_pc_selector=3, count unchanged. Ready and timeout on the same cycle → DECODE.
- Opcode 1111111 → trap cause 0 in the cycle after DECODE. rst_n dropped during MEMORY → all outputs 0 asynchronously, state=FETCH, retired_count=0.
